// File: rtl/supernova_mem_pkg.sv
// Shared FSM encoding and default widths for the supernova memory responder.
package supernova_mem_pkg;

  localparam int DEFAULT_XLEN           = 64;
  localparam int DEFAULT_PHYS_ADDR_SIZE = 56;
  localparam int LAT_CNT_W              = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } mem_state_e;

endpackage

// File: rtl/supernova_mem_array.sv
// Single-port backing store with byte write enables and a registered read;
// the read register only changes on a read access.
module supernova_mem_array #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 1024,
  localparam int BYTES = XLEN / 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [BYTES-1:0] wstrb,
  input  logic [AW-1:0]    addr,
  input  logic [XLEN-1:0]  wdata,
  output logic [XLEN-1:0]  rdata
);

  logic [XLEN-1:0] mem_reg [DEPTH];
  logic [XLEN-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb[b]) mem_reg[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en && !we) rdata_reg <= mem_reg[addr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/supernova_mem_responder.sv
// Fixed-latency memory responder: IDLE/BUSY/ACK handshake over a byte-enabled store.
// Optional macro SUPERNOVA_MEMRESP_PERF_EN adds rd/wr/err 64-bit event counters.
module supernova_mem_responder
  import supernova_mem_pkg::*;
#(
  parameter int XLEN           = DEFAULT_XLEN,
  parameter int PHYS_ADDR_SIZE = DEFAULT_PHYS_ADDR_SIZE,
  parameter int MEM_WORDS      = 1024,
  parameter int LATENCY        = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mem_req,
  input  logic                      mem_we,
  input  logic [PHYS_ADDR_SIZE-1:0] mem_addr,
  input  logic [XLEN-1:0]           mem_wdata,
  input  logic [7:0]                mem_wstrb,
  output logic                      mem_ack,
  output logic [XLEN-1:0]           mem_rdata,
  output logic                      mem_err
`ifdef SUPERNOVA_MEMRESP_PERF_EN
  ,
  output logic [63:0]               rd_count,
  output logic [63:0]               wr_count,
  output logic [63:0]               err_count
`endif
);

  localparam int AW    = $clog2(MEM_WORDS);
  localparam int BYTES = XLEN / 8;
  localparam logic [LAT_CNT_W-1:0] BUSY_LOAD = LAT_CNT_W'(LATENCY > 1 ? LATENCY - 2 : 0);

  mem_state_e           state_reg, state_next;
  logic [LAT_CNT_W-1:0] cnt_reg, cnt_next;
  logic                 we_reg, oor_reg;
  logic [AW-1:0]        idx_reg;
  logic [XLEN-1:0]      wdata_reg;
  logic [7:0]           wstrb_reg;
  logic                 rdata_zero_reg, rdata_zero_next;

  logic                 capture, enter_ack;
  logic                 in_oor;
  logic                 op_we, op_oor;
  logic [AW-1:0]        op_idx;
  logic [XLEN-1:0]      op_wdata;
  logic [7:0]           op_wstrb;
  logic                 ram_en;
  logic [XLEN-1:0]      ram_rdata;
  logic                 unused_addr_bits;

  assign unused_addr_bits = &{1'b0, mem_addr[2:0]};

  generate
    if (AW + 3 < PHYS_ADDR_SIZE) begin : g_oor
      assign in_oor = |mem_addr[PHYS_ADDR_SIZE-1:AW+3];
    end else begin : g_no_oor
      assign in_oor = 1'b0;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    enter_ack  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_req) begin
          capture = 1'b1;
          if (LATENCY == 1) begin
            state_next = ACK;
            enter_ack  = 1'b1;
          end else begin
            state_next = BUSY;
            cnt_next   = BUSY_LOAD;
          end
        end
      end
      BUSY: begin
        if (cnt_reg == '0) begin
          state_next = ACK;
          enter_ack  = 1'b1;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // With LATENCY=1 the access happens on the acceptance edge, so use live inputs.
  always_comb begin
    op_we    = capture ? mem_we    : we_reg;
    op_oor   = capture ? in_oor    : oor_reg;
    op_idx   = capture ? mem_addr[AW+2:3] : idx_reg;
    op_wdata = capture ? mem_wdata : wdata_reg;
    op_wstrb = capture ? mem_wstrb : wstrb_reg;
    ram_en   = enter_ack && !op_oor && rst_n;
    rdata_zero_next = rdata_zero_reg;
    if (enter_ack && !op_we) rdata_zero_next = op_oor;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      we_reg         <= 1'b0;
      oor_reg        <= 1'b0;
      idx_reg        <= '0;
      wdata_reg      <= '0;
      wstrb_reg      <= '0;
      rdata_zero_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      rdata_zero_reg <= rdata_zero_next;
      if (capture) begin
        we_reg    <= mem_we;
        oor_reg   <= in_oor;
        idx_reg   <= mem_addr[AW+2:3];
        wdata_reg <= mem_wdata;
        wstrb_reg <= mem_wstrb;
      end
    end
  end

  supernova_mem_array #(
    .XLEN  (XLEN),
    .DEPTH (MEM_WORDS)
  ) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (op_we),
    .wstrb (op_wstrb[BYTES-1:0]),
    .addr  (op_idx),
    .wdata (op_wdata),
    .rdata (ram_rdata)
  );

  // The RAM read register is masked rather than reset so it stays block-RAM friendly.
  assign mem_ack   = (state_reg == ACK);
  assign mem_err   = mem_ack && oor_reg;
  assign mem_rdata = rdata_zero_reg ? '0 : ram_rdata;

`ifdef SUPERNOVA_MEMRESP_PERF_EN
  logic [63:0] rd_count_reg, wr_count_reg, err_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_reg  <= '0;
      wr_count_reg  <= '0;
      err_count_reg <= '0;
    end else if (enter_ack) begin
      if (op_we) wr_count_reg <= wr_count_reg + 64'd1;
      else       rd_count_reg <= rd_count_reg + 64'd1;
      if (op_oor) err_count_reg <= err_count_reg + 64'd1;
    end
  end

  assign rd_count  = rd_count_reg;
  assign wr_count  = wr_count_reg;
  assign err_count = err_count_reg;
`endif

endmodule

// File: doc/supernova_mem_responder.md
SUPERNOVA_MEM_RESPONDER -- requirements
Module: supernova_mem_responder

Interface
REQ-001 SHALL have parameter XLEN, default 64, data width.
REQ-002 SHALL have parameter PHYS_ADDR_SIZE, default 56, request address width.
REQ-003 SHALL have parameter MEM_WORDS, default 1024, backing-store depth in XLEN words; power of two.
REQ-004 SHALL have parameter LATENCY, default 2, cycles from acceptance to ack; legal range 1..15.
REQ-005 SHALL have clk  input  1  clock.
REQ-006 SHALL have rst_n  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have mem_req  input  1  request valid; held by initiator until ack.
REQ-008 SHALL have mem_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have mem_addr  input  PHYS_ADDR_SIZE  byte address; bits [2:0] ignored.
REQ-010 SHALL have mem_wdata  input  XLEN  write data.
REQ-011 SHALL have mem_wstrb  input  8  byte enables; bit i enables byte i.
REQ-012 SHALL have mem_ack  output  1  single-cycle completion pulse.
REQ-013 SHALL have mem_rdata  output  XLEN  read data.
REQ-014 SHALL have mem_err  output  1  out-of-range flag, valid with mem_ack.

Function
REQ-015 SHALL implement FSM IDLE, BUSY, ACK; leave IDLE only on mem_req=1 at a clock edge (acceptance).
REQ-016 SHALL capture we, addr, wdata, wstrb at acceptance; later input changes are ignored until the next acceptance.
REQ-017 SHALL assert mem_ack exactly LATENCY cycles after the acceptance edge, for exactly one cycle; LATENCY=1 skips BUSY.
REQ-018 SHALL return ACK to IDLE unconditionally; mem_req during the ack cycle is never accepted, giving at most one ack per request.
REQ-019 SHALL form the word index from addr[2+log2(MEM_WORDS):3]; out-of-range when any addr bit above that field is 1.
REQ-020 SHALL, for an in-range write, update only the bytes enabled by wstrb at the edge entering ACK; wstrb=0 acks with no change.
REQ-021 SHALL, for an in-range read, load mem_rdata at the edge entering ACK and hold it until the next accepted read completes; writes leave mem_rdata unchanged.
REQ-022 SHALL, for out-of-range requests, assert mem_err with mem_ack, drive mem_rdata to 0 on reads, and suppress writes.
REQ-023 SHALL drive mem_err=0 whenever mem_ack=0.
REQ-024 SHALL make a write fully visible to the immediately following read of the same word.

Reset
REQ-025 SHALL, on rst_n=0, force IDLE, mem_ack=0, mem_err=0, mem_rdata=0, latency counter 0, and any counters 0, at any point including mid-BUSY; the pending request is discarded with no write.
REQ-026 SHALL NOT reset backing-store contents.

Configuration
REQ-027 SHALL, with SUPERNOVA_MEMRESP_PERF_EN defined, add 64-bit outputs rd_count, wr_count, err_count, each incremented on the ack edge of the matching request type; err_count counts out-of-range requests of either type.
REQ-028 SHALL, without SUPERNOVA_MEMRESP_PERF_EN, omit those ports and counters; all other behaviour is identical.

Structure
REQ-029 SHALL place the FSM state enum and the default XLEN/PHYS_ADDR_SIZE constants in package supernova_mem_pkg.
REQ-030 SHALL put the backing store in sub-module supernova_mem_array: one XLEN-wide synchronous read/write port with byte write enables.

Verification
REQ-031 Write addr 0x40, wdata 0x1122334455667788, wstrb 0xFF, LATENCY=2 -> mem_ack exactly 2 cycles after acceptance, mem_err=0; then read 0x40 -> rdata 0x1122334455667788.
REQ-032 Write addr 0x40, wdata 0xAAAAAAAAAAAAAAAA, wstrb 0x0F, then read 0x40 -> rdata 0x11223344AAAAAAAA.
REQ-033 Read addr 0x2000 with MEM_WORDS=1024 -> mem_ack with mem_err=1 and rdata 0; a follow-up write to 0x2000 is suppressed and a read of 0x0 is unchanged.
REQ-034 mem_req held high through the ack cycle -> exactly one ack; accept a second request only after one IDLE cycle; LATENCY=1 -> ack on the cycle after acceptance.
REQ-035 rst_n pulsed low during BUSY of a write to 0x80 -> no ack, outputs 0, word 0x80 unchanged on a later read.
REQ-036 With SUPERNOVA_MEMRESP_PERF_EN: 3 reads, 2 writes, 1 out-of-range read -> rd_count=4, wr_count=2, err_count=1.
